// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS BCD timekeeping core with run, pause and manual
// adjust modes. Advances on single-cycle ticks from the clock divider and
// drives the digit and status fields read by the seven-segment multiplexer.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_RUN    | count_tick advances the full MM:SS chain with carries
//   ST_PAUSED | digits frozen, both ticks ignored
//   ST_ADJUST | adj_tick advances only the field chosen by sel, no carry
//
// The state register always equals the decode of (adj_q, paused_q): ADJUST
// wins whenever adj_q is set, so a pause toggled while adjusting is simply
// remembered in paused_q and shows up as PAUSED or RUN once adj drops.
// SYNC_STAGES must be at least 2.
module stopwatch_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       count_tick,
  input  logic       adj_tick,
  input  logic       pause_btn,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       paused,
  output logic       adjusting,
  output logic [1:0] blink_field
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   btn_prev_q, btn_prev_d;
  logic                   btn_rise;

  logic paused_q, paused_d;
  logic adj_q, adj_d;

  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;

  logic [7:0] sec_next;
  logic [7:0] min_next;
  logic       sec_at_max;

  // One step of a 00..59 BCD field; 59 wraps to 00. Returns {tens, ones}.
  function automatic logic [7:0] bcd60_inc(input logic [3:0] tens,
                                           input logic [3:0] ones);
    logic [3:0] t;
    logic [3:0] o;
    t = tens;
    o = ones;
    if (ones == 4'd9) begin
      o = 4'd0;
      if (tens == 4'd5) begin
        t = 4'd0;
      end else begin
        t = tens + 4'd1;
      end
    end else begin
      o = ones + 4'd1;
    end
    return {t, o};
  endfunction

  // Button synchronizer shift and rising-edge detect against one extra flop.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], pause_btn};
    btn_prev_d = sync_q[SYNC_STAGES-1];
    btn_rise   = sync_q[SYNC_STAGES-1] & ~btn_prev_q;
  end

  // Synchronizer and edge-detect flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      btn_prev_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      btn_prev_q <= btn_prev_d;
    end
  end

  // Next pause flag, adjust sample and the mode they decode to.
  always_comb begin
    paused_d = paused_q ^ btn_rise;
    adj_d    = adj;
    state_d  = ST_RUN;
    if (adj_d) begin
      state_d = ST_ADJUST;
    end else if (paused_d) begin
      state_d = ST_PAUSED;
    end
  end

  // Mode register and the flags it is decoded from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      paused_q <= 1'b0;
      adj_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paused_q <= paused_d;
      adj_q    <= adj_d;
    end
  end

  // Digit update: full carry chain in RUN, single selected field in ADJUST.
  always_comb begin
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    sec_next   = bcd60_inc(sec_tens_q, sec_ones_q);
    min_next   = bcd60_inc(min_tens_q, min_ones_q);
    sec_at_max = (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);
    case (state_q)
      ST_RUN: begin
        if (count_tick) begin
          {sec_tens_d, sec_ones_d} = sec_next;
          if (sec_at_max) begin
            {min_tens_d, min_ones_d} = min_next;
          end
        end
      end
      ST_ADJUST: begin
        if (adj_tick) begin
          if (sel) begin
            {sec_tens_d, sec_ones_d} = sec_next;
          end else begin
            {min_tens_d, min_ones_d} = min_next;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Digit registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
    end else begin
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
    end
  end

  assign min_tens    = min_tens_q;
  assign min_ones    = min_ones_q;
  assign sec_tens    = sec_tens_q;
  assign sec_ones    = sec_ones_q;
  assign paused      = paused_q;
  assign adjusting   = adj_q;
  assign blink_field = adj_q ? (sel ? 2'b01 : 2'b10) : 2'b00;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: linear sequence of steps with
// hand-computed expected digit and status values.
module tb_stopwatch_core;

  logic       clk;
  logic       rst;
  logic       count_tick;
  logic       adj_tick;
  logic       pause_btn;
  logic       adj;
  logic       sel;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       paused;
  logic       adjusting;
  logic [1:0] blink_field;

  int n_cmp;
  int n_err;

  stopwatch_core #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .count_tick  (count_tick),
    .adj_tick    (adj_tick),
    .pause_btn   (pause_btn),
    .adj         (adj),
    .sel         (sel),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .paused      (paused),
    .adjusting   (adjusting),
    .blink_field (blink_field)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns past it.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic chk_status(input string tag, input logic exp_paused,
                            input logic exp_adj, input logic [1:0] exp_blink);
    chk(tag, {11'd0, paused, adjusting, 1'b0, blink_field},
        {11'd0, exp_paused, exp_adj, 1'b0, exp_blink});
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    count_tick = 1'b0;
    adj_tick   = 1'b0;
    pause_btn  = 1'b0;
    adj        = 1'b0;
    sel        = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);
    chk("reset_digits", digits(), 16'h0000);
    chk_status("reset_status", 1'b0, 1'b0, 2'b00);

    // 75 back-to-back count ticks
    count_tick = 1'b1;
    step(75);
    count_tick = 1'b0;
    chk("run75_digits", digits(), 16'h0115);
    chk_status("run75_status", 1'b0, 1'b0, 2'b00);

    // preload 59:58 through adjust
    adj = 1'b1;
    step(1);
    chk_status("adj_enter", 1'b0, 1'b1, 2'b10);
    adj_tick = 1'b1;
    step(58);
    sel = 1'b1;
    step(43);
    adj_tick = 1'b0;
    chk("preload_5958", digits(), 16'h5958);
    adj = 1'b0;
    step(1);
    chk_status("adj_exit", 1'b0, 1'b0, 2'b00);
    count_tick = 1'b1;
    step(1);
    chk("run_5959", digits(), 16'h5959);
    step(1);
    count_tick = 1'b0;
    chk("wrap_0000", digits(), 16'h0000);

    // pause press: toggles on the third edge only
    pause_btn = 1'b1;
    step(2);
    chk_status("pause_lat2", 1'b0, 1'b0, 2'b00);
    step(1);
    chk_status("pause_lat3", 1'b1, 1'b0, 2'b00);
    count_tick = 1'b1;
    step(10);
    count_tick = 1'b0;
    chk("paused_hold", digits(), 16'h0000);
    chk_status("pause_held_once", 1'b1, 1'b0, 2'b00);
    pause_btn = 1'b0;
    step(4);
    pause_btn = 1'b1;
    step(3);
    chk_status("unpause", 1'b0, 1'b0, 2'b00);
    count_tick = 1'b1;
    step(1);
    count_tick = 1'b0;
    chk("unpause_tick", digits(), 16'h0001);
    pause_btn = 1'b0;
    step(4);

    // adjust seconds to 00:58, then 3 more with count_tick held high
    adj = 1'b1;
    sel = 1'b1;
    step(1);
    adj_tick = 1'b1;
    step(57);
    adj_tick = 1'b0;
    chk("adj_0058", digits(), 16'h0058);
    adj_tick   = 1'b1;
    count_tick = 1'b1;
    step(3);
    adj_tick = 1'b0;
    chk("adj_sec_nocarry", digits(), 16'h0001);
    chk_status("blink_sec", 1'b0, 1'b1, 2'b01);
    sel      = 1'b0;
    adj_tick = 1'b1;
    step(2);
    adj_tick = 1'b0;
    chk("adj_min", digits(), 16'h0201);
    chk_status("blink_min", 1'b0, 1'b1, 2'b10);
    step(3);
    count_tick = 1'b0;
    chk("adj_ignores_count", digits(), 16'h0201);

    // pause toggled during adjust takes effect on exit
    pause_btn = 1'b1;
    step(3);
    pause_btn = 1'b0;
    chk_status("pause_in_adj", 1'b1, 1'b1, 2'b10);
    adj = 1'b0;
    step(1);
    chk_status("exit_to_paused", 1'b1, 1'b0, 2'b00);
    count_tick = 1'b1;
    adj_tick   = 1'b1;
    step(5);
    count_tick = 1'b0;
    adj_tick   = 1'b0;
    chk("paused_after_adj", digits(), 16'h0201);
    step(2);
    pause_btn = 1'b1;
    step(3);
    pause_btn = 1'b0;
    chk_status("resume", 1'b0, 1'b0, 2'b00);
    step(3);

    // set 12:34, run, then async reset between edges
    adj = 1'b1;
    step(1);
    sel      = 1'b0;
    adj_tick = 1'b1;
    step(10);
    sel = 1'b1;
    step(33);
    adj_tick = 1'b0;
    adj      = 1'b0;
    step(1);
    chk("preload_1234", digits(), 16'h1234);
    count_tick = 1'b1;
    step(3);
    chk("run_1237", digits(), 16'h1237);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_digits", digits(), 16'h0000);
    chk_status("async_rst_status", 1'b0, 1'b0, 2'b00);
    count_tick = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
    chk("post_rst", digits(), 16'h0000);

    // count_tick coincident with pause toggle at 00:09
    count_tick = 1'b1;
    step(9);
    count_tick = 1'b0;
    chk("run_0009", digits(), 16'h0009);
    pause_btn = 1'b1;
    step(2);
    count_tick = 1'b1;
    step(1);
    count_tick = 1'b0;
    chk("coincident_tick", digits(), 16'h0010);
    chk_status("coincident_paused", 1'b1, 1'b0, 2'b00);
    count_tick = 1'b1;
    step(1);
    count_tick = 1'b0;
    chk("coincident_hold", digits(), 16'h0010);
    pause_btn = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
